// File: rtl/wb_regfile_unit_if.sv
// Write-back stage bus: Wr-segment fields in, register read ports and write-back observation out.
interface wb_regfile_unit_if #(
    parameter int unsigned DW = 32
);
    logic [5:0]      wr_op;
    logic [5:0]      wr_func;
    logic [4:0]      wr_reg;
    logic            wr_reg_wr;
    logic            wr_mem_to_reg;
    logic [DW-1:0]   wr_alure;
    logic [DW-1:0]   wr_dout;
    logic [2*DW-1:0] wr_mult_result;
    logic [4:0]      rd_addr_a;
    logic [4:0]      rd_addr_b;
    logic [DW-1:0]   rd_data_a;
    logic [DW-1:0]   rd_data_b;
    logic [DW-1:0]   wb_data;
    logic [4:0]      wb_reg;
    logic            wb_en;
    logic [DW-1:0]   hi_q;
    logic [DW-1:0]   lo_q;
    logic [31:0]     wb_count;

    modport master (
        output wr_op, wr_func, wr_reg, wr_reg_wr, wr_mem_to_reg, wr_alure, wr_dout,
               wr_mult_result, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wb_data, wb_reg, wb_en, hi_q, lo_q, wb_count
    );

    modport slave (
        input  wr_op, wr_func, wr_reg, wr_reg_wr, wr_mem_to_reg, wr_alure, wr_dout,
               wr_mult_result, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wb_data, wb_reg, wb_en, hi_q, lo_q, wb_count
    );
endinterface

// File: rtl/wb_regfile_unit.sv
// MIPS write-back stage: selects the write-back datum, commits it to the 32x32 register file,
// maintains HI/LO and serves two bypassed read ports.
module wb_regfile_unit #(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    wb_regfile_unit_if.slave bus
);
    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpLb      = 6'h20;
    localparam logic [5:0] OpLh      = 6'h21;
    localparam logic [5:0] OpLbu     = 6'h24;
    localparam logic [5:0] OpLhu     = 6'h25;
    localparam logic [5:0] FnMfhi    = 6'h10;
    localparam logic [5:0] FnMthi    = 6'h11;
    localparam logic [5:0] FnMflo    = 6'h12;
    localparam logic [5:0] FnMtlo    = 6'h13;
    localparam logic [5:0] FnMult    = 6'h18;
    localparam logic [5:0] FnMultu   = 6'h19;

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic [31:0]   wb_count_q, wb_count_d;

    logic [7:0]    load_byte;
    logic [15:0]   load_half;
    logic [DW-1:0] load_data;
    logic [DW-1:0] wb_data;
    logic          wb_en;
    logic          is_special;

    assign is_special = (bus.wr_op == OpSpecial);
    assign wb_en      = bus.wr_reg_wr && (bus.wr_reg != 5'd0);

    // Little-endian lane selection from the low address bits.
    always_comb begin
        load_byte = 8'h00;
        unique case (bus.wr_alure[1:0])
            2'd0: load_byte = bus.wr_dout[7:0];
            2'd1: load_byte = bus.wr_dout[15:8];
            2'd2: load_byte = bus.wr_dout[23:16];
            2'd3: load_byte = bus.wr_dout[31:24];
            default: load_byte = 8'h00;
        endcase
        load_half = bus.wr_alure[1] ? bus.wr_dout[31:16] : bus.wr_dout[15:0];
    end

    always_comb begin
        load_data = bus.wr_dout;
        case (bus.wr_op)
            OpLb:    load_data = {{(DW-8){load_byte[7]}}, load_byte};
            OpLbu:   load_data = {{(DW-8){1'b0}}, load_byte};
            OpLh:    load_data = {{(DW-16){load_half[15]}}, load_half};
            OpLhu:   load_data = {{(DW-16){1'b0}}, load_half};
            default: load_data = bus.wr_dout;
        endcase
    end

    always_comb begin
        wb_data = bus.wr_alure;
        if (bus.wr_mem_to_reg) begin
            wb_data = load_data;
        end else if (is_special && bus.wr_func == FnMfhi) begin
            wb_data = hi_q;
        end else if (is_special && bus.wr_func == FnMflo) begin
            wb_data = lo_q;
        end
    end

    // HI/LO writes depend only on op/func; Wr_RegWr does not gate them.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (is_special) begin
            case (bus.wr_func)
                FnMult, FnMultu: begin
                    hi_d = bus.wr_mult_result[2*DW-1:DW];
                    lo_d = bus.wr_mult_result[DW-1:0];
                end
                FnMthi:  hi_d = bus.wr_alure;
                FnMtlo:  lo_d = bus.wr_alure;
                default: ;
            endcase
        end
    end

    always_comb begin
        wb_count_d = wb_count_q;
        if (wb_en) begin
            wb_count_d = wb_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            hi_q       <= '0;
            lo_q       <= '0;
            wb_count_q <= '0;
        end else begin
            if (wb_en) begin
                regs_q[bus.wr_reg] <= wb_data;
            end
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            wb_count_q <= wb_count_d;
        end
    end

    // Same-cycle bypass lets ID see a value before it lands in storage.
    always_comb begin
        bus.rd_data_a = regs_q[bus.rd_addr_a];
        if (bus.rd_addr_a == 5'd0) begin
            bus.rd_data_a = '0;
        end else if (wb_en && bus.rd_addr_a == bus.wr_reg) begin
            bus.rd_data_a = wb_data;
        end
    end

    always_comb begin
        bus.rd_data_b = regs_q[bus.rd_addr_b];
        if (bus.rd_addr_b == 5'd0) begin
            bus.rd_data_b = '0;
        end else if (wb_en && bus.rd_addr_b == bus.wr_reg) begin
            bus.rd_data_b = wb_data;
        end
    end

    assign bus.wb_data  = wb_data;
    assign bus.wb_reg   = bus.wr_reg;
    assign bus.wb_en    = wb_en;
    assign bus.hi_q     = hi_q;
    assign bus.lo_q     = lo_q;
    assign bus.wb_count = wb_count_q;
endmodule

// File: doc/wb_regfile_unit.md
Name: wb_regfile_unit

Overview:
- Write-back end of the five-stage MIPS pipeline; consumes the Wr_* fields produced by the Mem/Wr segment register.
- Selects the write-back datum: ALU result, load data with sub-word extraction, or HI/LO.
- Commits the datum to the 32x32 general register file and maintains the HI/LO pair for MULT/MULTU/MTHI/MTLO.
- Serves the two ID-stage read ports with write-through bypass, and exports the write-back bus for forwarding.

Parameters:
- NREG, 32, number of general registers (address width fixed at 5)
- DW, 32, data width

Ports:
- clk  in  1  pipeline clock; all state updates on posedge (segment registers update on negedge)
- rst  in  1  asynchronous, active-high reset
- Wr_op  in  6  opcode of the instruction in Wr
- Wr_func  in  6  function field
- Wr_Reg  in  5  destination register number
- Wr_RegWr  in  1  register-file write enable
- Wr_MemtoReg  in  1  select load data
- Wr_alure  in  32  ALU result / effective address
- Wr_dout  in  32  raw memory word
- Wr_MULT_result  in  64  product; [63:32] to HI, [31:0] to LO
- rd_addr_a  in  5  read port A address (rs)
- rd_addr_b  in  5  read port B address (rt)
- rd_data_a  out  32  read port A data
- rd_data_b  out  32  read port B data
- wb_data  out  32  selected write-back datum (combinational)
- wb_reg  out  5  equals Wr_Reg
- wb_en  out  1  Wr_RegWr && (Wr_Reg != 0)
- hi_q  out  32  HI register
- lo_q  out  32  LO register
- wb_count  out  32  count of committed register writes

Behaviour:
- Reset (async, rst=1): all 32 registers, HI, LO and wb_count clear to 0 immediately. Outputs then read 0 except the combinational wb_* outputs. Reset asserted mid-stream discards any write pending that cycle.
- Load extraction, applied when Wr_MemtoReg=1. Byte lane = Wr_alure[1:0]; little-endian, lane 0 = dout[7:0]. Halfword lane = Wr_alure[1], lane 0 = dout[15:0].
  - LB 0x20: sign-extend byte
  - LBU 0x24: zero-extend byte
  - LH 0x21: sign-extend halfword
  - LHU 0x25: zero-extend halfword
  - LW 0x23 and any other op: full word
- wb_data priority:
  1. Wr_MemtoReg: extracted load data
  2. op=0, func=0x10 (MFHI): hi_q
  3. op=0, func=0x12 (MFLO): lo_q
  4. otherwise: Wr_alure
- Register write: on posedge, if wb_en then reg[Wr_Reg] <= wb_data and wb_count increments. wb_count wraps at 2^32-1 -> 0.
- reg[0] reads 0 always; writes to it are dropped and not counted.
- HI/LO update on posedge, op=0 only, independent of Wr_RegWr:
  - func 0x18/0x19 (MULT/MULTU): {HI,LO} <= Wr_MULT_result
  - func 0x11 (MTHI): HI <= Wr_alure
  - func 0x13 (MTLO): LO <= Wr_alure
- MFHI immediately following a MULT sees the new HI. The MULT commits at posedge before the MFHI reaches Wr at the next negedge.
- Read ports (combinational):
  - Address 0 -> 0.
  - Else if wb_en and the address equals Wr_Reg -> wb_data (same-cycle bypass).
  - Else the stored register.
  - Both ports may hit the bypass simultaneously.
- Latency: a write is visible through the bypass in its own cycle and from storage after the next posedge.
- No stall or valid input; a bubble is encoded as Wr_RegWr=0 with op/func not matching any HI/LO-writing function.

Test Plan:
- Reset check: rst=1 then 0 -> rd_data_a/b=0 for all addresses; hi_q=lo_q=0; wb_count=0.
- Load extraction: Wr_RegWr=1, Wr_Reg=5, MemtoReg=1, dout=0x8899AABB.
  - LB, alure=...1 -> reg5=0xFFFFFFAA
  - LBU, alure=...1 -> 0x000000AA
  - LH, alure=...2 -> 0xFFFF8899
  - LW -> 0x8899AABB
- Bypass: write 0x12345678 to r7 with rd_addr_a=rd_addr_b=7 -> both read 0x12345678 in the same cycle. Write to r0 -> read 0, wb_count unchanged.
- HI/LO: MULT with result 0x00000001_FFFFFFFE -> hi_q=1, lo_q=0xFFFFFFFE. Next MFHI to r3 -> r3=1. MTLO alure=0x55 -> lo_q=0x55, hi_q unchanged.
- Reset mid-write: assert rst while wb_en=1 to r9 with data 0xDEAD -> r9=0 and wb_count=0 after rst release.
- Counter: 10 back-to-back writes to r1..r10 plus 3 bubbles -> wb_count=10.
